// File: rtl/serial_link_sched.sv
`default_nettype none
// ============================================================================
// Module      : serial_link_sched
// Description : Sequencer for the half-duplex sen/sd serial link between
//               station S1 and station S2. It grants the link S1->S2 (phase
//               A), inserts a bus turnaround gap, then grants S2->S1
//               (phase B). It also checks sen framing, runs a per-phase
//               watchdog and reports completion or the error cause.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               start     - 1-cycle pulse, starts a run from IDLE/DONE/ERR
//               abort     - synchronous return to IDLE, highest priority
//               s1_done   - S1 finished receiving (ends phase B)
//               s2_done   - S2 finished receiving (ends phase A)
//               sen       - monitored link enable, low = frame in progress
//               updown    - 0: S1 transmits, 1: S2 transmits
//               xfer_en   - stations may drive the link
//               busy      - run in progress (PH_A, TURN, PH_B)
//               all_done  - run completed
//               err       - run ended in error
//               err_code  - 00 none, 01 phase-A timeout, 10 phase-B timeout
//               len_err   - sticky: some frame had the wrong length
//               frame_cnt - frames completed in this run (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_link_sched #(
    parameter int FRAME_LEN = 13,
    parameter int TURN_CYC  = 4,
    parameter int TIMEOUT   = 4096,
    parameter int FCNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s1_done,
    input  logic              s2_done,
    input  logic              sen,
    output logic              updown,
    output logic              xfer_en,
    output logic              busy,
    output logic              all_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              len_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int c_WD_W  = $clog2(TIMEOUT + 1);
    localparam int c_LEN_W = $clog2(2 * FRAME_LEN + 1);

    localparam logic [c_WD_W-1:0]  c_WD_LAST   = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX   = c_LEN_W'(2 * FRAME_LEN);
    localparam logic [c_LEN_W-1:0] c_LEN_OK    = c_LEN_W'(FRAME_LEN);
    localparam logic [3:0]         c_TURN_LAST = 4'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH_A = 3'd1,
        S_TURN = 3'd2,
        S_PH_B = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_WD_W-1:0]   r_wd;
    logic [3:0]          r_turn;
    logic                r_sen_q;
    logic                r_open;
    logic [c_LEN_W-1:0]  r_len;

    logic                r_updown;
    logic                r_xfer_en;
    logic                r_busy;
    logic                r_all_done;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                r_len_err;
    logic [FCNT_W-1:0]   r_frame_cnt;

    logic                w_in_phase;
    logic                w_rise;
    logic                w_open_nxt;
    logic [c_LEN_W-1:0]  w_len_nxt;
    logic                w_bad_close;
    logic [FCNT_W-1:0]   w_fcnt_inc;
    logic                w_done;
    logic                w_timeout;

    assign w_in_phase = (r_state == S_PH_A) || (r_state == S_PH_B);
    assign w_done     = (r_state == S_PH_A) ? s2_done : s1_done;
    assign w_timeout  = (r_wd == c_WD_LAST);
    assign w_fcnt_inc = (r_frame_cnt == {FCNT_W{1'b1}}) ? r_frame_cnt
                                                        : r_frame_cnt + 1'b1;

    // Frame tracker next state. sen is only looked at inside a phase so an
    // undriven link during turnaround never reaches the tracker.
    always_comb begin
        w_rise      = 1'b0;
        w_open_nxt  = r_open;
        w_len_nxt   = r_len;
        if (w_in_phase) begin
            if (!sen && r_sen_q) begin
                // Falling edge: this low cycle is the first one of the frame.
                w_open_nxt = 1'b1;
                w_len_nxt  = c_LEN_W'(1);
            end else if (sen && !r_sen_q) begin
                w_rise     = 1'b1;
                w_open_nxt = 1'b0;
            end else if (!sen && r_open && (r_len != c_LEN_MAX)) begin
                w_len_nxt  = r_len + 1'b1;
            end
        end
    end

    assign w_bad_close = w_rise && (r_len != c_LEN_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_turn      <= '0;
            r_sen_q     <= 1'b1;
            r_open      <= 1'b0;
            r_len       <= '0;
            r_updown    <= 1'b0;
            r_xfer_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_len_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_turn      <= '0;
            r_sen_q     <= 1'b1;
            r_open      <= 1'b0;
            r_len       <= '0;
            r_updown    <= 1'b0;
            r_xfer_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_len_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    r_sen_q <= 1'b1;
                    if (start) begin
                        r_state     <= S_PH_A;
                        r_wd        <= '0;
                        r_open      <= 1'b0;
                        r_len       <= '0;
                        r_updown    <= 1'b0;
                        r_xfer_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_all_done  <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_code  <= 2'b00;
                        r_len_err   <= 1'b0;
                        r_frame_cnt <= '0;
                    end
                end

                S_PH_A, S_PH_B: begin
                    r_sen_q <= sen;
                    r_open  <= w_open_nxt;
                    r_len   <= w_len_nxt;
                    if (w_rise) begin
                        r_frame_cnt <= w_fcnt_inc;
                    end
                    if (w_bad_close) begin
                        r_len_err <= 1'b1;
                    end

                    if (w_done || w_timeout) begin
                        // Leaving the phase: an unfinished frame is an error
                        // and the tracker restarts idle for the next phase.
                        r_sen_q <= 1'b1;
                        r_open  <= 1'b0;
                        r_wd    <= '0;
                        if (w_open_nxt) begin
                            r_len_err <= 1'b1;
                        end
                        r_xfer_en <= 1'b0;
                        if (w_done && (r_state == S_PH_A)) begin
                            r_state  <= S_TURN;
                            r_turn   <= '0;
                            r_updown <= 1'b1;
                        end else if (w_done) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_all_done <= 1'b1;
                            r_updown   <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_updown   <= 1'b0;
                            r_err_code <= (r_state == S_PH_A) ? 2'b01 : 2'b10;
                        end
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_TURN: begin
                    r_sen_q <= 1'b1;
                    if (r_turn == c_TURN_LAST) begin
                        r_state   <= S_PH_B;
                        r_wd      <= '0;
                        r_open    <= 1'b0;
                        r_len     <= '0;
                        r_xfer_en <= 1'b1;
                    end else begin
                        r_turn <= r_turn + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign updown    = r_updown;
    assign xfer_en   = r_xfer_en;
    assign busy      = r_busy;
    assign all_done  = r_all_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign len_err   = r_len_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
